// File: rtl/clbmac_if.sv
// clbmac_if: operand/result handshake bundle for the clbmac hard block.
//   I1, I0  : multiplicand, multiplier/addend (WIDTH)
//   CTRL    : operation select (0 MUL, 1 MAC, 2 ADD, 3 CLR)
//   IVALID / IREADY : operand-side handshake
//   QVALID / QREADY : result-side handshake
//   Q, COUT : narrowed result and overflow flag
//   BUSY    : multiplier iterating
interface clbmac_if #(
   parameter int unsigned WIDTH = 16
);
   logic [WIDTH-1:0] I1;
   logic [WIDTH-1:0] I0;
   logic [1:0]       CTRL;
   logic             IVALID;
   logic             IREADY;
   logic             QVALID;
   logic             QREADY;
   logic [WIDTH-1:0] Q;
   logic             COUT;
   logic             BUSY;

   modport master (
      output I1, I0, CTRL, IVALID, QREADY,
      input  IREADY, QVALID, Q, COUT, BUSY
   );

   modport slave (
      input  I1, I0, CTRL, IVALID, QREADY,
      output IREADY, QVALID, Q, COUT, BUSY
   );
endinterface

// File: rtl/clbmac.sv
// clbmac: sequential multiply-accumulate block with a persistent wide
// accumulator, bit-serial shift-add multiplier, and scaled/saturated output.
//   C   : clock, rising edge
//   R   : asynchronous active-low reset
//   bus : clbmac_if slave (operands, op, handshakes, Q, COUT, BUSY)
module clbmac #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned ACC_GUARD = 4,
   parameter bit          SIGNED    = 1'b0,
   parameter int unsigned OUT_SHIFT = 0,
   parameter bit          SATURATE  = 1'b1
) (
   input logic     C,
   input logic     R,
   clbmac_if.slave bus
);
   localparam int unsigned ACC_W  = 2*WIDTH + ACC_GUARD;
   localparam int unsigned PROD_W = 2*WIDTH;
   localparam int unsigned CNT_W  = $clog2(WIDTH + 1);

   localparam logic [1:0] OP_MUL = 2'd0;
   localparam logic [1:0] OP_MAC = 2'd1;
   localparam logic [1:0] OP_ADD = 2'd2;

   typedef enum logic [1:0] {ST_IDLE, ST_MULT, ST_OUT} state_e;

   state_e             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [PROD_W-1:0]  mcand_q, mcand_d;
   logic [PROD_W-1:0]  prod_q, prod_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               mac_q, mac_d;
   logic               neg_q, neg_d;
   logic               ready_q, ready_d;
   logic               qvalid_q, qvalid_d;
   logic               busy_q, busy_d;
   logic               cout_q, cout_d;
   logic [WIDTH-1:0]   q_q, q_d;

   logic [WIDTH-1:0]   mag1_c, mag0_c;
   logic [PROD_W-1:0]  prod_fin_c;
   logic [ACC_W-1:0]   prod_zx_c, prod_ext_c, addend_c;
   logic [ACC_W-1:0]   shifted_c;
   logic [WIDTH-1:0]   nq_c;
   logic               ovf_c;

   // Operand magnitudes; the most negative value maps to its WIDTH-bit unsigned magnitude.
   always_comb begin : mag
      mag1_c = (SIGNED && bus.I1[WIDTH-1]) ? WIDTH'(-bus.I1) : bus.I1;
      mag0_c = (SIGNED && bus.I0[WIDTH-1]) ? WIDTH'(-bus.I0) : bus.I0;
      addend_c = {{(ACC_W-WIDTH){SIGNED && bus.I0[WIDTH-1]}}, bus.I0};
   end

   // Last partial product folded in combinationally, then signed and widened.
   always_comb begin : prod
      prod_fin_c = prod_q + (mplier_q[0] ? mcand_q : '0);
      prod_zx_c  = ACC_W'(prod_fin_c);
      prod_ext_c = neg_q ? (-prod_zx_c) : prod_zx_c;
   end

   // Next-state, accumulator and multiplier datapath.
   always_comb begin : next
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      mac_d    = mac_q;
      neg_d    = neg_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.IVALID && ready_q) begin
               case (bus.CTRL)
                  OP_MUL, OP_MAC: begin
                     state_d  = ST_MULT;
                     cnt_d    = CNT_W'(WIDTH);
                     mcand_d  = PROD_W'(mag1_c);
                     mplier_d = mag0_c;
                     prod_d   = '0;
                     mac_d    = (bus.CTRL == OP_MAC);
                     neg_d    = SIGNED && (bus.I1[WIDTH-1] ^ bus.I0[WIDTH-1]);
                  end
                  OP_ADD: begin
                     acc_d   = acc_q + addend_c;
                     state_d = ST_OUT;
                  end
                  default: begin
                     acc_d   = '0;
                     state_d = ST_OUT;
                  end
               endcase
            end
         end
         ST_MULT: begin
            prod_d   = prod_fin_c;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               acc_d   = mac_q ? (acc_q + prod_ext_c) : prod_ext_c;
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            if (bus.QREADY) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Scale and narrow the upcoming accumulator value.
   always_comb begin : narrow
      if (OUT_SHIFT >= ACC_W)
         shifted_c = {ACC_W{SIGNED && acc_d[ACC_W-1]}};
      else if (SIGNED)
         shifted_c = $signed(acc_d) >>> OUT_SHIFT;
      else
         shifted_c = acc_d >> OUT_SHIFT;

      if (SIGNED)
         ovf_c = !((&shifted_c[ACC_W-1:WIDTH-1]) || !(|shifted_c[ACC_W-1:WIDTH-1]));
      else
         ovf_c = |shifted_c[ACC_W-1:WIDTH];

      if (ovf_c && SATURATE) begin
         if (!SIGNED)
            nq_c = '1;
         else if (shifted_c[ACC_W-1])
            nq_c = {1'b1, {(WIDTH-1){1'b0}}};
         else
            nq_c = {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         nq_c = shifted_c[WIDTH-1:0];
      end
   end

   // Registered outputs; Q/COUT captured only on entry to OUT.
   always_comb begin : outs
      ready_d  = (state_d == ST_IDLE);
      busy_d   = (state_d == ST_MULT);
      qvalid_d = (state_d == ST_OUT);
      q_d      = q_q;
      cout_d   = cout_q;
      if (state_d == ST_OUT && state_q != ST_OUT) begin
         q_d    = nq_c;
         cout_d = ovf_c;
      end
   end

   always_ff @(posedge C or negedge R) begin : regs
      if (!R) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         mac_q    <= 1'b0;
         neg_q    <= 1'b0;
         ready_q  <= 1'b0;
         qvalid_q <= 1'b0;
         busy_q   <= 1'b0;
         cout_q   <= 1'b0;
         q_q      <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         mac_q    <= mac_d;
         neg_q    <= neg_d;
         ready_q  <= ready_d;
         qvalid_q <= qvalid_d;
         busy_q   <= busy_d;
         cout_q   <= cout_d;
         q_q      <= q_d;
      end
   end

   assign bus.IREADY = ready_q;
   assign bus.QVALID = qvalid_q;
   assign bus.BUSY   = busy_q;
   assign bus.COUT   = cout_q;
   assign bus.Q      = q_q;
endmodule
